// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor for traffic light heads: flags invalid codes, conflicting
// open heads and illegal colour sequences, latches the first fault and drives flash-red.
module traffic_conflict_monitor #(
   parameter int                           N_HEADS      = 4,
   parameter logic [N_HEADS*N_HEADS-1:0]   CONFLICT_MAP = 16'h4812,
   parameter int                           FILT_CYC     = 2,
   parameter int                           MIN_YELLOW   = 3,
   parameter int                           FLASH_HALF   = 4,
   localparam int                          HW           = (N_HEADS > 1) ? $clog2(N_HEADS) : 1,
   localparam int                          FW           = $clog2(FLASH_HALF + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3*N_HEADS-1:0]   lights_in,
   input  logic                   clr_fault,
   output logic                   fault,
   output logic [1:0]             fault_code,
   output logic [HW-1:0]          fault_head,
   output logic                   flash_red,
   output logic [7:0]             fault_cnt
);

   // state | meaning
   // MON   | watching the heads, no fault latched
   // FAULT | fault latched, flash_red toggling, waiting for a clean clr_fault
   typedef enum logic {MON, FAULT} state_t;

   localparam logic [2:0] C_RED = 3'b100;
   localparam logic [2:0] C_YEL = 3'b010;
   localparam logic [2:0] C_GRN = 3'b001;
   localparam logic [3:0] FC_MAX = 4'(FILT_CYC);
   localparam logic [3:0] YC_MAX = 4'(MIN_YELLOW);

   state_t                 state, state_nxt;
   logic [3*N_HEADS-1:0]   s, p;
   logic [3:0]             ycnt [N_HEADS];
   logic [3:0]             inv_fc, cf_fc;
   logic [FW-1:0]          flash_tmr;
   logic                   seq_mask;

   logic                   inv_any, cf_any, seq_any;
   logic [HW-1:0]          inv_head, cf_head, seq_head;
   logic                   inv_raise, cf_raise;
   logic                   latch, release_flt;

   function automatic logic is_valid(input logic [2:0] c);
      return (c == C_RED) || (c == C_YEL) || (c == C_GRN);
   endfunction

   // Loops run from the top head down so the lowest offending index wins.
   always_comb begin
      inv_any  = 1'b0;
      inv_head = '0;
      cf_any   = 1'b0;
      cf_head  = '0;
      seq_any  = 1'b0;
      seq_head = '0;
      for (int i = N_HEADS - 1; i >= 0; i--) begin
         if (!is_valid(s[3*i +: 3])) begin
            inv_any  = 1'b1;
            inv_head = i[HW-1:0];
         end
         for (int j = N_HEADS - 1; j > i; j--) begin
            if (CONFLICT_MAP[i*N_HEADS+j] && (s[3*i +: 3] != C_RED) && (s[3*j +: 3] != C_RED)) begin
               cf_any  = 1'b1;
               cf_head = i[HW-1:0];
            end
         end
         if (!seq_mask && is_valid(s[3*i +: 3]) && is_valid(p[3*i +: 3])) begin
            if (((p[3*i +: 3] == C_GRN) && (s[3*i +: 3] == C_RED)) ||
                ((p[3*i +: 3] == C_YEL) && (s[3*i +: 3] == C_GRN)) ||
                ((p[3*i +: 3] == C_RED) && (s[3*i +: 3] == C_YEL)) ||
                ((p[3*i +: 3] == C_YEL) && (s[3*i +: 3] == C_RED) && (ycnt[i] < YC_MAX))) begin
               seq_any  = 1'b1;
               seq_head = i[HW-1:0];
            end
         end
      end
   end

   // Raise on the sample that brings the filter up to FILT_CYC.
   assign inv_raise = inv_any && (inv_fc >= 4'(FILT_CYC - 1));
   assign cf_raise  = cf_any  && (cf_fc  >= 4'(FILT_CYC - 1));

   always_comb begin
      state_nxt   = state;
      latch       = 1'b0;
      release_flt = 1'b0;
      case (state)
         MON: begin
            if (inv_raise || cf_raise || seq_any) begin
               latch     = 1'b1;
               state_nxt = FAULT;
            end
         end
         FAULT: begin
            if (clr_fault && !inv_any && !cf_any && !seq_any) begin
               release_flt = 1'b1;
               state_nxt   = MON;
            end
         end
         default: state_nxt = MON;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= MON;
      else      state <= state_nxt;
   end

   assign fault = (state == FAULT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s          <= {N_HEADS{C_RED}};
         p          <= {N_HEADS{C_RED}};
         inv_fc     <= '0;
         cf_fc      <= '0;
         seq_mask   <= 1'b0;
         fault_code <= 2'd0;
         fault_head <= '0;
         flash_red  <= 1'b0;
         flash_tmr  <= '0;
         fault_cnt  <= 8'd0;
         for (int i = 0; i < N_HEADS; i++) ycnt[i] <= YC_MAX;
      end else begin
         s        <= lights_in;
         p        <= s;
         // The first pair after a release straddles the clear and is not judged.
         seq_mask <= release_flt;

         if (release_flt) begin
            inv_fc <= '0;
            cf_fc  <= '0;
         end else begin
            inv_fc <= inv_any ? ((inv_fc == FC_MAX) ? inv_fc : inv_fc + 4'd1) : 4'd0;
            cf_fc  <= cf_any  ? ((cf_fc  == FC_MAX) ? cf_fc  : cf_fc  + 4'd1) : 4'd0;
         end

         for (int i = 0; i < N_HEADS; i++) begin
            if (release_flt)
               ycnt[i] <= YC_MAX;
            else if (s[3*i +: 3] == C_YEL)
               ycnt[i] <= (p[3*i +: 3] != C_YEL) ? 4'd1 :
                          (ycnt[i] == YC_MAX)    ? ycnt[i] : ycnt[i] + 4'd1;
         end

         if (latch) begin
            fault_code <= inv_raise ? 2'd1 : cf_raise ? 2'd2 : 2'd3;
            fault_head <= inv_raise ? inv_head : cf_raise ? cf_head : seq_head;
            flash_red  <= 1'b1;
            flash_tmr  <= FW'(FLASH_HALF - 1);
            if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
         end else if (release_flt) begin
            fault_code <= 2'd0;
            fault_head <= '0;
            flash_red  <= 1'b0;
            flash_tmr  <= '0;
         end else if (state == FAULT) begin
            if (flash_tmr == '0) begin
               flash_red <= ~flash_red;
               flash_tmr <= FW'(FLASH_HALF - 1);
            end else begin
               flash_tmr <= flash_tmr - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_traffic_conflict_monitor;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [11:0] ALLRED = {R, R, R, R};
   localparam int HALF = 4;

   logic        clk, rst, clr_fault;
   logic [11:0] lights_in;
   logic        fault, flash_red;
   logic [1:0]  fault_code, fault_head;
   logic [7:0]  fault_cnt;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int         cyc;
      string      name;
      logic       f;
      logic [1:0] code;
      logic [1:0] head;
      logic       fl;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];

   traffic_conflict_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .lights_in  (lights_in),
      .clr_fault  (clr_fault),
      .fault      (fault),
      .fault_code (fault_code),
      .fault_head (fault_head),
      .flash_red  (flash_red),
      .fault_cnt  (fault_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] L(input logic [2:0] h3, input logic [2:0] h2,
                                     input logic [2:0] h1, input logic [2:0] h0);
      return {h3, h2, h1, h0};
   endfunction

   // Flash is high for HALF cycles starting at the entry edge, then alternates.
   function automatic logic flash_at(input int tgt, input int entry);
      return (((tgt - entry) / HALF) % 2) == 0;
   endfunction

   task automatic expect_out(input int tgt, input string nm, input logic f, input logic [1:0] c,
                             input logic [1:0] h, input logic fl, input logic [7:0] n);
      exp_t e;
      e.cyc = tgt; e.name = nm; e.f = f; e.code = c; e.head = h; e.fl = fl; e.cnt = n;
      q.push_back(e);
   endtask

   task automatic apply(input logic [11:0] l, input logic c);
      @(negedge clk);
      lights_in = l;
      clr_fault = c;
   endtask

   task automatic hold(input logic [11:0] l, input int n);
      for (int i = 0; i < n; i++) apply(l, 1'b0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || fault !== e.f || fault_code !== e.code || fault_head !== e.head ||
                flash_red !== e.fl || fault_cnt !== e.cnt) begin
               n_err++;
               $display("FAIL %s @cyc %0d (due %0d): got fault=%b code=%0d head=%0d flash=%b cnt=%0d, want fault=%b code=%0d head=%0d flash=%b cnt=%0d",
                        e.name, cyc, e.cyc, fault, fault_code, fault_head, flash_red, fault_cnt,
                        e.f, e.code, e.head, e.fl, e.cnt);
            end
         end
      end
   end

   initial begin
      int t, e_cyc;
      rst = 1'b0;
      lights_in = ALLRED;
      clr_fault = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      apply(ALLRED, 1'b0);
      t = cyc;
      expect_out(t + 1, "reset", 0, 0, 0, 0, 0);

      // three full legal cycles, heads 0 and 1 alternating
      for (int c = 0; c < 3; c++) begin
         hold(L(R, R, R, G), 20);
         hold(L(R, R, R, Y), 4);
         hold(L(R, R, G, R), 20);
         hold(L(R, R, Y, R), 4);
         expect_out(cyc + 1, "normal", 0, 0, 0, 0, 0);
      end
      hold(ALLRED, 2);

      // short yellow on head 0
      hold(L(R, R, R, G), 3);
      hold(L(R, R, R, Y), 2);
      apply(ALLRED, 1'b0);
      t = cyc;
      e_cyc = t + 2;
      expect_out(t + 1,  "sy_latency", 0, 0, 0, 0, 0);
      expect_out(t + 2,  "sy_fault",   1, 3, 0, flash_at(t + 2,  e_cyc), 1);
      expect_out(t + 5,  "sy_flash_h", 1, 3, 0, flash_at(t + 5,  e_cyc), 1);
      expect_out(t + 6,  "sy_flash_l", 1, 3, 0, flash_at(t + 6,  e_cyc), 1);
      expect_out(t + 9,  "sy_flash_l2", 1, 3, 0, flash_at(t + 9, e_cyc), 1);
      expect_out(t + 10, "sy_flash_h2", 1, 3, 0, flash_at(t + 10, e_cyc), 1);
      hold(ALLRED, 12);
      apply(ALLRED, 1'b1);
      expect_out(cyc + 1, "sy_clear", 0, 0, 0, 0, 1);
      apply(ALLRED, 1'b0);

      // one-sample conflict between heads 2 and 3 is filtered out
      hold(L(G, R, R, R), 3);
      hold(L(Y, R, R, R), 3);
      apply(L(Y, G, R, R), 1'b0);
      hold(L(R, G, R, R), 3);
      expect_out(cyc + 1, "cf_glitch", 0, 0, 0, 0, 1);

      // two-sample conflict faults
      apply(L(G, G, R, R), 1'b0);
      t = cyc;
      e_cyc = t + 3;
      apply(L(G, G, R, R), 1'b0);
      expect_out(t + 2, "cf_latency", 0, 0, 0, 0, 1);
      expect_out(t + 3, "cf_fault",   1, 2, 2, flash_at(t + 3, e_cyc), 2);
      hold(L(G, G, R, R), 3);
      apply(L(G, G, R, R), 1'b1);
      expect_out(cyc + 1, "clr_blocked", 1, 2, 2, flash_at(cyc + 1, e_cyc), 2);
      hold(L(Y, G, R, R), 3);
      hold(L(R, G, R, R), 2);
      apply(L(R, G, R, R), 1'b1);
      expect_out(cyc + 1, "cf_clear", 0, 0, 0, 0, 2);
      apply(L(R, G, R, R), 1'b0);

      // invalid head 0 together with a 0/1 conflict: invalid wins
      apply(L(R, G, G, 3'b111), 1'b0);
      t = cyc;
      apply(L(R, G, G, 3'b111), 1'b0);
      expect_out(t + 2, "inv_latency", 0, 0, 0, 0, 2);
      expect_out(t + 3, "inv_fault",   1, 1, 0, 1, 3);
      hold(L(R, G, G, 3'b111), 5);

      // asynchronous reset between edges
      @(posedge clk);
      #3;
      rst = 1'b0;
      expect_out(cyc, "async_rst", 0, 0, 0, 0, 0);
      apply(ALLRED, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      hold(ALLRED, 2);
      expect_out(cyc + 1, "post_rst", 0, 0, 0, 0, 0);

      // yellow of exactly the minimum length, unmapped pair 0/2 open together
      hold(L(R, G, R, G), 2);
      hold(L(R, G, R, Y), 3);
      hold(L(R, G, R, R), 3);
      expect_out(cyc + 1, "yellow_min", 0, 0, 0, 0, 0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (q.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
